gradient_magnitude_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational gradient-magnitude stage of the Canny edge detector.
- Takes signed Sobel gx/gy samples and computes a scaled, saturated magnitude, selectable per sample between L1 and approximate-L2.
- Also quantises gradient direction into four sectors for the downstream non-maximum-suppression stage.
- Sits between the Sobel convolution stage and NMS, with a valid/ready stream handshake on both sides.

---
 rtl/gradient_pkg.sv | 21 ++
 rtl/grad_dir_quant.sv | 40 ++++
 rtl/gradient_magnitude_pipe.sv | 134 +++++++++++++
 tb/tb_gradient_magnitude_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_pkg.sv
// Shared types and constants for the gradient-magnitude stage and its
// downstream consumers (direction sectors, magnitude mode).
package gradient_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } gdir_t;

    typedef enum logic {
        MODE_L1  = 1'b0,
        MODE_L2A = 1'b1
    } gmode_t;

    // tan(22.5deg) ~= DIR_DEN/DIR_NUM = 0.4
    localparam int DIR_NUM = 5;
    localparam int DIR_DEN = 2;

endpackage

// File: rtl/grad_dir_quant.sv
// Combinational quantiser of gradient direction into four sectors from
// absolute gradient components and their sign agreement.
module grad_dir_quant
    import gradient_pkg::*;
#(
    parameter int IN_W = 11
) (
    input  logic [IN_W-1:0] i_ax,
    input  logic [IN_W-1:0] i_ay,
    input  logic            i_same_sign,
    output gdir_t           o_gdir
);

    localparam int PW = IN_W + 3;

    logic [PW-1:0] w_ay_num;
    logic [PW-1:0] w_ax_den;
    logic [PW-1:0] w_ax_num;
    logic [PW-1:0] w_ay_den;

    assign w_ay_num = PW'(i_ay) * PW'(DIR_NUM);
    assign w_ax_den = PW'(i_ax) * PW'(DIR_DEN);
    assign w_ax_num = PW'(i_ax) * PW'(DIR_NUM);
    assign w_ay_den = PW'(i_ay) * PW'(DIR_DEN);

    // Near-horizontal wins first, so ax=ay=0 falls into sector 0.
    always_comb begin
        o_gdir = DIR_0;
        if (w_ay_num <= w_ax_den) begin
            o_gdir = DIR_0;
        end else if (w_ax_num <= w_ay_den) begin
            o_gdir = DIR_90;
        end else if (i_same_sign) begin
            o_gdir = DIR_45;
        end else begin
            o_gdir = DIR_135;
        end
    end

endmodule

// File: rtl/gradient_magnitude_pipe.sv
// Three-stage valid/ready pipeline: Sobel gx/gy -> scaled, saturated
// L1 / approx-L2 magnitude plus a 4-sector direction for NMS.
module gradient_magnitude_pipe
    import gradient_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] gx,
    input  logic signed [IN_W-1:0] gy,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       gmag,
    output logic [1:0]             gdir,
    output logic                   sat
);

    localparam int RAW_W = IN_W + 1;

    if (IN_W < 2 || OUT_W < 1 || SHIFT < 0 || SHIFT > IN_W) begin : g_bad_params
        $error("gradient_magnitude_pipe: illegal IN_W/OUT_W/SHIFT");
    end

    logic              w_advance;
    logic [IN_W-1:0]   w_ax;
    logic [IN_W-1:0]   w_ay;
    logic [IN_W-1:0]   w_mx;
    logic [IN_W-1:0]   w_mn;
    logic [RAW_W-1:0]  w_raw;
    gdir_t             w_dir;
    logic [RAW_W-1:0]  w_s;
    logic [OUT_W-1:0]  w_gmag;
    logic              w_sat;

    logic              r_s1_valid;
    logic [IN_W-1:0]   r_s1_ax;
    logic [IN_W-1:0]   r_s1_ay;
    logic              r_s1_same;
    gmode_t            r_s1_mode;
    logic              r_s2_valid;
    logic [RAW_W-1:0]  r_s2_raw;
    gdir_t             r_s2_dir;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_gmag;
    gdir_t             r_gdir;
    logic              r_sat;

    // Whole pipe moves in lock-step; bubbles are kept, not collapsed.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Magnitude of the most negative input is still representable unsigned.
    assign w_ax = gx[IN_W-1] ? -gx : gx;
    assign w_ay = gy[IN_W-1] ? -gy : gy;

    // Stage-2 magnitude: L1 sum or max + min/2.
    always_comb begin
        w_mx  = r_s1_ax;
        w_mn  = r_s1_ay;
        w_raw = '0;
        if (r_s1_ax >= r_s1_ay) begin
            w_mx = r_s1_ax;
            w_mn = r_s1_ay;
        end else begin
            w_mx = r_s1_ay;
            w_mn = r_s1_ax;
        end
        if (r_s1_mode == MODE_L2A) begin
            w_raw = RAW_W'(w_mx) + RAW_W'(w_mn >> 1);
        end else begin
            w_raw = RAW_W'(r_s1_ax) + RAW_W'(r_s1_ay);
        end
    end

    grad_dir_quant #(.IN_W(IN_W)) u_dir_quant (
        .i_ax        (r_s1_ax),
        .i_ay        (r_s1_ay),
        .i_same_sign (r_s1_same),
        .o_gdir      (w_dir)
    );

    assign w_s = r_s2_raw >> SHIFT;

    if (OUT_W >= RAW_W) begin : g_no_clip
        assign w_sat  = 1'b0;
        assign w_gmag = OUT_W'(w_s);
    end else begin : g_clip
        assign w_sat  = |w_s[RAW_W-1:OUT_W];
        assign w_gmag = w_sat ? {OUT_W{1'b1}} : w_s[OUT_W-1:0];
    end

    // Pipeline registers for all three stages, frozen when stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_ax     <= '0;
            r_s1_ay     <= '0;
            r_s1_same   <= 1'b0;
            r_s1_mode   <= MODE_L1;
            r_s2_valid  <= 1'b0;
            r_s2_raw    <= '0;
            r_s2_dir    <= DIR_0;
            r_out_valid <= 1'b0;
            r_gmag      <= '0;
            r_gdir      <= DIR_0;
            r_sat       <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s1_ax     <= w_ax;
            r_s1_ay     <= w_ay;
            r_s1_same   <= (gx[IN_W-1] == gy[IN_W-1]);
            r_s1_mode   <= gmode_t'(mode);
            r_s2_valid  <= r_s1_valid;
            r_s2_raw    <= w_raw;
            r_s2_dir    <= w_dir;
            r_out_valid <= r_s2_valid;
            r_gmag      <= w_gmag;
            r_gdir      <= r_s2_dir;
            r_sat       <= w_sat;
        end
    end

    assign out_valid = r_out_valid;
    assign gmag      = r_gmag;
    assign gdir      = r_gdir;
    assign sat       = r_sat;

endmodule

// File: tb/tb_gradient_magnitude_pipe.sv
// Self-checking bench: directed literal vectors, reset flush, backpressure
// and a randomized soak against a behavioural scoreboard model.
module tb_gradient_magnitude_pipe;

    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
    localparam int SHIFT = 3;

    logic                   clk = 1'b0;
    logic                   n_rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [IN_W-1:0] gx = '0;
    logic signed [IN_W-1:0] gy = '0;
    logic                   mode = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [OUT_W-1:0]       gmag;
    logic [1:0]             gdir;
    logic                   sat;

    int errors = 0;
    int checks = 0;
    int n_popped = 0;
    logic [10:0] exp_q[$];

    gradient_magnitude_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gx        (gx),
        .gy        (gy),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gmag      (gmag),
        .gdir      (gdir),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {gmag[7:0], gdir[1:0], sat} straight from the arithmetic rules.
    function automatic logic [10:0] model(input int x, input int y, input bit m);
        int ax, ay, mx, mn, raw, s, d;
        bit st;
        logic [10:0] r;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        raw = m ? (mx + mn / 2) : (ax + ay);
        s = raw / (1 << SHIFT);
        st = (s > 255);
        if (st) s = 255;
        if (5 * ay <= 2 * ax)      d = 0;
        else if (5 * ax <= 2 * ay) d = 2;
        else if ((x < 0) == (y < 0)) d = 1;
        else d = 3;
        r = {s[7:0], d[1:0], st};
        return r;
    endfunction

    function automatic int pick();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -1024;
        if (r == 1) return 1023;
        if (r == 2) return 0;
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    // Per-cycle monitor: handshake rule, stall stability, scoreboard.
    initial begin
        logic        prev_stall;
        logic [10:0] prev_out;
        logic [10:0] e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
                if (prev_stall) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_hold", int'({gmag, gdir, sat}), int'(prev_out));
                end
                if (in_valid && in_ready) exp_q.push_back(model(gx, gy, mode));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: gmag %0d with empty scoreboard at %0t", gmag, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_gmag", int'(gmag), int'(e[10:3]));
                        chk("sb_gdir", int'(gdir), int'(e[2:1]));
                        chk("sb_sat", int'(sat), int'(e[0]));
                        n_popped++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {gmag, gdir, sat};
            end
        end
    end

    task automatic directed(input string nm, input int x, input int y, input bit m,
                            input int eg, input int ed, input int es);
        int lat;
        bit got;
        @(posedge clk); #1;
        gx = x[IN_W-1:0]; gy = y[IN_W-1:0]; mode = m;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (out_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_gmag"}, int'(gmag), eg);
        chk({nm, "_gdir"}, int'(gdir), ed);
        chk({nm, "_sat"}, int'(sat), es);
        @(posedge clk); #1;
    endtask

    initial begin
        int seen, sent, stall_left, acc, p0, v;
        bit started;

        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_gmag", int'(gmag), 0);
        chk("rst_gdir", int'(gdir), 0);
        chk("rst_sat", int'(sat), 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        directed("zero",    0,     0,     1'b0, 0,   0, 0);
        directed("l1_a",    800,   -40,   1'b0, 105, 0, 0);
        directed("l1_sat",  -1024, -1024, 1'b0, 255, 1, 1);
        directed("l1_edge", 1020,  1020,  1'b0, 255, 1, 0);
        directed("l2_90",   100,   300,   1'b1, 43,  2, 0);
        directed("l2_135",  200,   -200,  1'b1, 37,  3, 0);
        directed("l2_0",    -300,  -100,  1'b1, 43,  0, 0);

        // Mid-stream reset with two samples in flight
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; gx = 11'sd700; gy = 11'sd600; mode = 1'b0;
        @(posedge clk); #1;
        gx = -11'sd900; gy = 11'sd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_gmag", int'(gmag), 0);
        chk("async_rst_sat", int'(sat), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_stale_after_rst", seen, 0);

        // Backpressure: 8 back-to-back, 6-cycle stall after first result
        p0 = n_popped; sent = 0; stall_left = 0; started = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid && !started) begin
                started = 1'b1;
                stall_left = 6;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (sent < 8);
            v = pick(); gx = v[IN_W-1:0];
            v = pick(); gy = v[IN_W-1:0];
            mode = 1'($urandom_range(0, 1));
            #1;
            if (!out_ready) chk("bp_in_ready_low", int'(in_ready), 0);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_started", int'(started), 1);
        chk("bp_count", n_popped - p0, 8);
        chk("bp_q_empty", exp_q.size(), 0);

        // Random soak
        acc = 0;
        p0 = n_popped;
        for (int c = 0; c < 40000 && acc < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            v = pick(); gx = v[IN_W-1:0];
            v = pick(); gy = v[IN_W-1:0];
            mode = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("soak_accepted", acc, 10000);
        chk("soak_delivered", n_popped - p0, acc);
        chk("soak_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
